// File: rtl/axi_lite_slave_ctrl_pkg.sv
// Shared AXI4-lite definitions for the axi_lite_slave_ctrl block:
// response codes, protection bit positions and the controller state encoding.
package axi_lite_slave_ctrl_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AxPROT bit positions (carried on the bus, not interpreted by this slave)
    localparam int PROT_PRIV_BIT   = 0;
    localparam int PROT_NSEC_BIT   = 1;
    localparam int PROT_INSTR_BIT  = 2;

    // Width of the optional read-wait counter
    localparam int RD_TIMER_WIDTH = 16;

    // Controller states; one transaction in flight at a time
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        WR_ISSUE   = 3'd2,
        WR_RESP    = 3'd3,
        RD_ISSUE   = 3'd4,
        RD_WAIT    = 3'd5,
        RD_RESP    = 3'd6
    } state_t;

    // Map an IP error qualifier to an AXI response code
    function automatic logic [1:0] err_to_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_slave_ctrl.sv
// AXI4-lite slave front end that turns single bus transactions into
// one-cycle write/read strobes on a simple register-style IP interface.
// Optional feature macro: AXI_SLV_RD_TIMEOUT_EN -- when defined, a read that
// sees no ip_rd_valid within TIMEOUT cycles completes with SLVERR and zero data.
module axi_lite_slave_ctrl
    import axi_lite_slave_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]            AWPROT,

    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,

    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,

    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]            ARPROT,

    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,

    output logic [ADDR_WIDTH-1:0] ip_addr,
    output logic [DATA_WIDTH-1:0] ip_wr_data,
    output logic [STRB_WIDTH-1:0] ip_wr_strb,
    output logic                  ip_wr_en,
    output logic                  ip_rd_en,
    input  logic [DATA_WIDTH-1:0] ip_rd_data,
    input  logic                  ip_rd_valid,
    input  logic                  ip_err
);

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_aw_got;
    logic                  r_w_got;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_timeout_hit;

    // Protection bits are accepted but carry no meaning for this slave
    logic                  w_unused_ok;
    assign w_unused_ok = &{1'b0, AWPROT, ARPROT, (TIMEOUT > 0)};

    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID  & WREADY;
    assign w_ar_hs = ARVALID & ARREADY;

`ifdef AXI_SLV_RD_TIMEOUT_EN
    logic [RD_TIMER_WIDTH-1:0] r_rd_timer;

    // Count cycles spent waiting for IP read data; cleared outside RD_WAIT
    always_ff @(posedge ACLK) begin
        if (ARESET || (r_state != RD_WAIT)) begin
            r_rd_timer <= '0;
        end else begin
            r_rd_timer <= r_rd_timer + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th wait cycle so the response follows right after
    assign w_timeout_hit = (r_state == RD_WAIT) &&
                           (r_rd_timer == RD_TIMER_WIDTH'(TIMEOUT - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/strobe outputs
    always_comb begin
        w_state_next = r_state;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        ARREADY      = 1'b0;
        BVALID       = 1'b0;
        RVALID       = 1'b0;
        ip_wr_en     = 1'b0;
        ip_rd_en     = 1'b0;

        case (r_state)
            IDLE: begin
                AWREADY = 1'b1;
                WREADY  = 1'b1;
                // Writes take priority: hold off AR while any write beat is offered
                ARREADY = ~(AWVALID | WVALID);
                if (AWVALID && WVALID) begin
                    w_state_next = WR_ISSUE;
                end else if (AWVALID || WVALID) begin
                    w_state_next = WR_COLLECT;
                end else if (ARVALID) begin
                    w_state_next = RD_ISSUE;
                end
            end

            WR_COLLECT: begin
                AWREADY = ~r_aw_got;
                WREADY  = ~r_w_got;
                if ((!r_aw_got && AWVALID) || (!r_w_got && WVALID)) begin
                    w_state_next = WR_ISSUE;
                end
            end

            WR_ISSUE: begin
                ip_wr_en     = 1'b1;
                w_state_next = WR_RESP;
            end

            WR_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    w_state_next = IDLE;
                end
            end

            RD_ISSUE: begin
                ip_rd_en     = 1'b1;
                w_state_next = RD_WAIT;
            end

            RD_WAIT: begin
                if (ip_rd_valid || w_timeout_hit) begin
                    w_state_next = RD_RESP;
                end
            end

            RD_RESP: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        // While reset is held nothing may be accepted or strobed
        if (ARESET) begin
            AWREADY  = 1'b0;
            WREADY   = 1'b0;
            ARREADY  = 1'b0;
            BVALID   = 1'b0;
            RVALID   = 1'b0;
            ip_wr_en = 1'b0;
            ip_rd_en = 1'b0;
        end
    end

    // Capture accepted beats, write status and read return data
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rdata  <= '0;
            r_bresp  <= RESP_OKAY;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_addr   <= AWADDR;
                r_aw_got <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
                r_w_got <= 1'b1;
            end
            // ARREADY is never high together with AWREADY&&AWVALID, so no clash on r_addr
            if (w_ar_hs) begin
                r_addr <= ARADDR;
            end
            if (r_state == WR_ISSUE) begin
                r_bresp  <= err_to_resp(ip_err);
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
            end
            if (r_state == RD_WAIT) begin
                if (ip_rd_valid) begin
                    r_rdata <= ip_rd_data;
                    r_rresp <= err_to_resp(ip_err);
                end else if (w_timeout_hit) begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end
            end
        end
    end

    assign ip_addr    = r_addr;
    assign ip_wr_data = r_wdata;
    assign ip_wr_strb = r_wstrb;
    assign RDATA      = r_rdata;
    assign BRESP      = r_bresp;
    assign RRESP      = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// Self-checking bench for axi_lite_slave_ctrl: directed scenarios plus
// randomized traffic checked against a word-addressed reference memory.
module tb_axi_lite_slave_ctrl;

    localparam int TB_TIMEOUT = 8;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWVALID = 1'b0, AWREADY;
    logic [31:0] AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        WVALID = 1'b0, WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID, BREADY = 1'b0;
    logic [1:0]  BRESP;
    logic        ARVALID = 1'b0, ARREADY;
    logic [31:0] ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        RVALID, RREADY = 1'b0;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [31:0] ip_addr, ip_wr_data;
    logic [3:0]  ip_wr_strb;
    logic        ip_wr_en, ip_rd_en;
    logic [31:0] ip_rd_data = '0;
    logic        ip_rd_valid = 1'b0;
    logic        ip_err;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_slave_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .ip_addr(ip_addr), .ip_wr_data(ip_wr_data), .ip_wr_strb(ip_wr_strb),
        .ip_wr_en(ip_wr_en), .ip_rd_en(ip_rd_en), .ip_rd_data(ip_rd_data),
        .ip_rd_valid(ip_rd_valid), .ip_err(ip_err)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- IP stand-in: storage, latency, error region ----------------
    logic [31:0] ip_mem [64];
    int          ip_delay   = 0;
    bit          ip_respond = 1'b1;
    bit          ip_pend    = 1'b0;
    int          ip_rem     = 0;

    function automatic int mem_idx(input logic [31:0] a);
        return int'({a[11:10], a[5:2]});
    endfunction

    // Addresses with bits [11:10] == 2'b11 belong to a faulting region
    assign ip_err = (ip_addr[11:10] == 2'b11);

    always @(posedge ACLK) begin
        ip_rd_valid <= 1'b0;
        if (ARESET) begin
            ip_pend <= 1'b0;
            ip_rem  <= 0;
            for (int i = 0; i < 64; i++) ip_mem[i] <= '0;
        end else begin
            if (ip_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (ip_wr_strb[b]) ip_mem[mem_idx(ip_addr)][b*8 +: 8] <= ip_wr_data[b*8 +: 8];
            end
            if (ip_rd_en && ip_respond) begin
                if (ip_delay == 0) begin
                    ip_rd_valid <= 1'b1;
                    ip_rd_data  <= ip_mem[mem_idx(ip_addr)];
                end else begin
                    ip_pend <= 1'b1;
                    ip_rem  <= ip_delay;
                end
            end else if (ip_pend) begin
                if (ip_rem == 1) begin
                    ip_rd_valid <= 1'b1;
                    ip_rd_data  <= ip_mem[mem_idx(ip_addr)];
                    ip_pend     <= 1'b0;
                end else begin
                    ip_rem <= ip_rem - 1;
                end
            end
        end
    end

    // ---------------- Activity monitor ----------------
    int cyc = 0, wr_pulses = 0, rd_pulses = 0, rvalid_rises = 0;
    int last_rd_en_cyc = 0, last_rvalid_cyc = 0;
    bit rvalid_prev = 1'b0;
    int wr_cycles [$];

    always @(posedge ACLK) begin
        cyc         <= cyc + 1;
        rvalid_prev <= RVALID;
        if (ip_wr_en) begin
            wr_pulses <= wr_pulses + 1;
            wr_cycles.push_back(cyc);
        end
        if (ip_rd_en) begin
            rd_pulses      <= rd_pulses + 1;
            last_rd_en_cyc <= cyc;
        end
        if (RVALID && !rvalid_prev) begin
            rvalid_rises    <= rvalid_rises + 1;
            last_rvalid_cyc <= cyc;
        end
    end

    // ---------------- Reference model: expected memory contents ----------------
    logic [31:0] exp_mem [64];

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) exp_mem[mem_idx(a)][b*8 +: 8] = d[b*8 +: 8];
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (a[11:10] == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    // ---------------- Bus master tasks ----------------
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output bit done);
        bit aw_done = 0, w_done = 0;
        int bwait = 0;
        done = 0; resp = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge ACLK);
            AWADDR = a; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && (c >= aw_dly);
            WVALID  = !w_done && (c >= w_dly);
            if (BVALID) begin BREADY = (bwait >= b_dly); bwait++; end
            else BREADY = 1'b0;
            #4;
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            if (BVALID && BREADY) begin resp = BRESP; done = 1; end
        end
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; BREADY = 0;
        $display("WR addr=%h data=%h strb=%h resp=%0d done=%0d", a, d, s, resp, done);
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output bit done);
        bit ar_done = 0;
        int rwait = 0;
        done = 0; data = '0; resp = '0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge ACLK);
            ARADDR  = a;
            ARVALID = !ar_done;
            if (RVALID) begin RREADY = (rwait >= r_dly); rwait++; end
            else RREADY = 1'b0;
            #4;
            if (ARVALID && ARREADY) ar_done = 1;
            if (RVALID && RREADY) begin data = RDATA; resp = RRESP; done = 1; end
        end
        @(negedge ACLK);
        ARVALID = 0; RREADY = 0;
        $display("RD addr=%h data=%h resp=%0d done=%0d", a, data, resp, done);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            ARESET = 1; AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 1; RREADY = 1;
            #4;
            n_cmp++;
            if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, ip_wr_en, ip_rd_en} !== 7'b0) begin
                n_err++; $display("FAIL reset_ctrl got=%b want=0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, ip_wr_en, ip_rd_en});
            end
        end
        n_cmp++;
        if ({ip_addr, ip_wr_data, ip_wr_strb, RDATA, BRESP, RRESP} !== '0) begin
            n_err++; $display("FAIL reset_data addr=%h wdata=%h strb=%h rdata=%h bresp=%0d rresp=%0d want all 0",
                              ip_addr, ip_wr_data, ip_wr_strb, RDATA, BRESP, RRESP);
        end
        @(negedge ACLK);
        ARESET = 0; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
        clear_exp();
        #4;
        n_cmp++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL reset_release_ready got=%b want=111", {AWREADY, WREADY, ARREADY});
        end
        $display("RESET done");
    endtask

    task automatic test_single_write();
        int p0 = wr_pulses;
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 32'h10; WVALID = 1; WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; BREADY = 1;
        #4;
        n_cmp++;
        if ({AWREADY, WREADY} !== 2'b11) begin
            n_err++; $display("FAIL sw_ready got=%b want=11", {AWREADY, WREADY});
        end
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        #4;
        n_cmp++;
        if ({ip_wr_en, ip_addr, ip_wr_data, ip_wr_strb} !== {1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF}) begin
            n_err++; $display("FAIL sw_issue en=%b addr=%h data=%h strb=%h want 1/10/a5a5a5a5/f",
                              ip_wr_en, ip_addr, ip_wr_data, ip_wr_strb);
        end
        @(negedge ACLK);
        #4;
        n_cmp++;
        if ({BVALID, BRESP, ip_wr_en} !== {1'b1, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL sw_bresp bvalid=%b bresp=%0d wr_en=%b want 1/0/0", BVALID, BRESP, ip_wr_en);
        end
        @(negedge ACLK);
        BREADY = 0;
        #4;
        n_cmp++;
        if ({BVALID, AWREADY, wr_pulses - p0} !== {1'b0, 1'b1, 32'd1}) begin
            n_err++; $display("FAIL sw_done bvalid=%b awready=%b pulses=%0d want 0/1/1", BVALID, AWREADY, wr_pulses - p0);
        end
        exp_write(32'h10, 32'hA5A5_A5A5, 4'hF);
        $display("WR addr=00000010 data=a5a5a5a5 strb=f (directed)");
    endtask

    task automatic test_w_before_aw();
        int p0 = wr_pulses;
        @(negedge ACLK);
        WVALID = 1; WDATA = 32'hCAFE_0020; WSTRB = 4'b0101; BREADY = 1;
        #4;
        n_cmp++;
        if (WREADY !== 1'b1) begin n_err++; $display("FAIL wfirst_wready got=%b want=1", WREADY); end
        @(negedge ACLK);
        WVALID = 0;
        #4;
        n_cmp++;
        if ({WREADY, AWREADY, ARREADY, ip_wr_en} !== 4'b0100) begin
            n_err++; $display("FAIL wfirst_collect w/aw/ar/en=%b want 0100", {WREADY, AWREADY, ARREADY, ip_wr_en});
        end
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 32'h20;
        #4;
        n_cmp++;
        if ({AWREADY, WREADY, wr_pulses - p0} !== {2'b10, 32'd0}) begin
            n_err++; $display("FAIL wfirst_aw awready=%b wready=%b pulses=%0d want 1/0/0", AWREADY, WREADY, wr_pulses - p0);
        end
        @(negedge ACLK);
        AWVALID = 0;
        #4;
        n_cmp++;
        if ({ip_wr_en, ip_addr, ip_wr_data, ip_wr_strb} !== {1'b1, 32'h20, 32'hCAFE_0020, 4'b0101}) begin
            n_err++; $display("FAIL wfirst_issue en=%b addr=%h data=%h strb=%h want 1/20/cafe0020/5",
                              ip_wr_en, ip_addr, ip_wr_data, ip_wr_strb);
        end
        @(negedge ACLK);
        @(negedge ACLK);
        BREADY = 0;
        #4;
        n_cmp++;
        if (wr_pulses - p0 !== 1) begin n_err++; $display("FAIL wfirst_pulses got=%0d want=1", wr_pulses - p0); end
        exp_write(32'h20, 32'hCAFE_0020, 4'b0101);
        $display("WR addr=00000020 data=cafe0020 strb=5 (W before AW)");
    endtask

    task automatic test_read_backpressure();
        logic [1:0] r; bit ok; bit got = 0; int p0;
        axi_write(32'h30, 32'h1234_5678, 4'hF, 0, 0, 0, r, ok);
        exp_write(32'h30, 32'h1234_5678, 4'hF);
        n_cmp++;
        if (!ok || r !== 2'b00) begin n_err++; $display("FAIL rbp_prewrite done=%0d resp=%0d want 1/0", ok, r); end
        p0 = rd_pulses;
        ip_delay = 3;
        @(negedge ACLK);
        ARVALID = 1; ARADDR = 32'h30; RREADY = 0;
        #4;
        n_cmp++;
        if (ARREADY !== 1'b1) begin n_err++; $display("FAIL rbp_arready got=%b want=1", ARREADY); end
        @(negedge ACLK);
        ARVALID = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            #4;
            if (RVALID) got = 1;
            else @(negedge ACLK);
        end
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL rbp_rvalid_timeout got=0 want=1"); end
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            RREADY = 0;
            #4;
            n_cmp++;
            if ({RVALID, RDATA, RRESP, ARREADY} !== {1'b1, 32'h1234_5678, 2'b00, 1'b0}) begin
                n_err++; $display("FAIL rbp_hold rvalid=%b rdata=%h rresp=%0d arready=%b want 1/12345678/0/0",
                                  RVALID, RDATA, RRESP, ARREADY);
            end
        end
        @(negedge ACLK);
        RREADY = 1;
        #4;
        n_cmp++;
        if (RVALID !== 1'b1) begin n_err++; $display("FAIL rbp_accept rvalid=%b want=1", RVALID); end
        @(negedge ACLK);
        RREADY = 0;
        #4;
        n_cmp++;
        if ({RVALID, ARREADY, rd_pulses - p0} !== {2'b01, 32'd1}) begin
            n_err++; $display("FAIL rbp_done rvalid=%b arready=%b rd_pulses=%0d want 0/1/1", RVALID, ARREADY, rd_pulses - p0);
        end
        ip_delay = 0;
        $display("RD addr=00000030 data=12345678 (backpressure)");
    endtask

    task automatic test_simultaneous();
        int p0 = wr_pulses;
        bit ar_done = 0, r_done = 0;
        logic [31:0] rd = '0;
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 32'h40; WVALID = 1; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
        ARVALID = 1; ARADDR = 32'h40; BREADY = 1; RREADY = 1;
        #4;
        n_cmp++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b110) begin
            n_err++; $display("FAIL sim_prio aw/w/ar=%b want 110", {AWREADY, WREADY, ARREADY});
        end
        exp_write(32'h40, 32'h0BAD_F00D, 4'hF);
        for (int c = 0; c < 40 && !r_done; c++) begin
            @(negedge ACLK);
            AWVALID = 0; WVALID = 0; ARVALID = !ar_done;
            #4;
            if (ARVALID && ARREADY) begin
                ar_done = 1;
                n_cmp++;
                if (wr_pulses - p0 !== 1) begin
                    n_err++; $display("FAIL sim_order wr_pulses_at_ar=%0d want=1", wr_pulses - p0);
                end
            end
            if (RVALID && RREADY) begin r_done = 1; rd = RDATA; end
        end
        @(negedge ACLK);
        ARVALID = 0; BREADY = 0; RREADY = 0;
        n_cmp++;
        if (!r_done || rd !== exp_mem[mem_idx(32'h40)]) begin
            n_err++; $display("FAIL sim_readback done=%0d data=%h want %h", r_done, rd, exp_mem[mem_idx(32'h40)]);
        end
        $display("WR+RD addr=00000040 data=%h (simultaneous)", rd);
    endtask

    task automatic test_error_resp();
        logic [1:0] r; logic [31:0] d; bit ok;
        axi_write(32'hC08, 32'h5555_AAAA, 4'hF, 0, 1, 0, r, ok);
        exp_write(32'hC08, 32'h5555_AAAA, 4'hF);
        n_cmp++;
        if (!ok || r !== 2'b10) begin n_err++; $display("FAIL err_bresp done=%0d resp=%0d want 1/2", ok, r); end
        axi_read(32'hC08, 0, d, r, ok);
        n_cmp++;
        if (!ok || r !== 2'b10 || d !== exp_mem[mem_idx(32'hC08)]) begin
            n_err++; $display("FAIL err_rresp done=%0d resp=%0d data=%h want 1/2/%h", ok, r, d, exp_mem[mem_idx(32'hC08)]);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int n0 = wr_cycles.size();
        logic [31:0] d;
        BREADY = 1;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            @(negedge ACLK);
            d = 32'hB2B0_0000 + 32'(idx);
            AWVALID = 1; WVALID = 1; AWADDR = 32'h80 + 32'(idx * 4); WDATA = d; WSTRB = 4'hF;
            #4;
            if (AWREADY && WREADY) begin
                exp_write(AWADDR, d, 4'hF);
                idx++;
            end
        end
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        repeat (4) @(negedge ACLK);
        BREADY = 0;
        n_cmp++;
        if (wr_cycles.size() - n0 !== 4) begin
            n_err++; $display("FAIL b2b_count got=%0d want=4", wr_cycles.size() - n0);
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (wr_cycles[n0 + i] - wr_cycles[n0 + i - 1] !== 3) begin
                    n_err++; $display("FAIL b2b_interval%0d got=%0d want=3", i, wr_cycles[n0 + i] - wr_cycles[n0 + i - 1]);
                end
            end
        end
        $display("WR x4 addr=00000080.. back-to-back");
    endtask

    task automatic test_timeout();
`ifdef AXI_SLV_RD_TIMEOUT_EN
        logic [1:0] r; logic [31:0] d; bit ok;
        ip_respond = 0;
        axi_read(32'h14, 0, d, r, ok);
        n_cmp++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            n_err++; $display("FAIL tmo_resp done=%0d data=%h resp=%0d want 1/0/2", ok, d, r);
        end
        n_cmp++;
        if (last_rvalid_cyc - last_rd_en_cyc !== TB_TIMEOUT + 1) begin
            n_err++; $display("FAIL tmo_latency got=%0d want=%0d", last_rvalid_cyc - last_rd_en_cyc, TB_TIMEOUT + 1);
        end
        ip_respond = 1;
`endif
    endtask

    task automatic test_reset_mid_write();
        int p0 = wr_pulses;
        @(negedge ACLK);
        WVALID = 1; WDATA = 32'hDEAD_0001; WSTRB = 4'hF;
        @(negedge ACLK);
        WVALID = 0; ARESET = 1;
        @(negedge ACLK);
        ARESET = 0;
        clear_exp();
        #4;
        n_cmp++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL rstw_ready got=%b want=111", {AWREADY, WREADY, ARREADY});
        end
        repeat (4) @(negedge ACLK);
        n_cmp++;
        if (wr_pulses - p0 !== 0 || BVALID !== 1'b0) begin
            n_err++; $display("FAIL rstw_abandon pulses=%0d bvalid=%b want 0/0", wr_pulses - p0, BVALID);
        end
        $display("WR abandoned by reset");
    endtask

    task automatic test_reset_mid_read();
        int p0 = rd_pulses;
        int v0 = rvalid_rises;
        ip_respond = 0;
        @(negedge ACLK);
        ARVALID = 1; ARADDR = 32'h60; RREADY = 1;
        @(negedge ACLK);
        ARVALID = 0;
        repeat (4) @(negedge ACLK);
        #4;
        n_cmp++;
        if ({RVALID, ARREADY, AWREADY} !== 3'b000) begin
            n_err++; $display("FAIL rstr_wait rvalid/ar/aw=%b want 000", {RVALID, ARREADY, AWREADY});
        end
        @(negedge ACLK);
        ARESET = 1;
        #4;
        n_cmp++;
        if ({RVALID, ip_rd_en, ARREADY} !== 3'b000) begin
            n_err++; $display("FAIL rstr_during rvalid/rd_en/ar=%b want 000", {RVALID, ip_rd_en, ARREADY});
        end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 0;
        clear_exp();
        #4;
        n_cmp++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL rstr_release got=%b want=111", {AWREADY, WREADY, ARREADY});
        end
        repeat (10) @(negedge ACLK);
        RREADY = 0;
        n_cmp++;
        if (rvalid_rises - v0 !== 0 || rd_pulses - p0 !== 1) begin
            n_err++; $display("FAIL rstr_abandon rvalid_rises=%0d rd_pulses=%0d want 0/1", rvalid_rises - v0, rd_pulses - p0);
        end
        ip_respond = 1;
        $display("RD abandoned by reset");
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] r; bit ok;
        for (int t = 0; t < 40; t++) begin
            a = (($urandom_range(0, 3) == 0) ? 32'hC00 : 32'h000) | (32'($urandom_range(0, 15)) << 2);
            AWPROT = 3'($urandom); ARPROT = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(1, 15));
                axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r, ok);
                exp_write(a, d, s);
                n_cmp++;
                if (!ok || r !== exp_resp(a)) begin
                    n_err++; $display("FAIL rnd_wr%0d addr=%h done=%0d resp=%0d want 1/%0d", t, a, ok, r, exp_resp(a));
                end
            end else begin
                ip_delay = $urandom_range(0, 5);
                axi_read(a, $urandom_range(0, 2), rd, r, ok);
                n_cmp++;
                if (!ok || r !== exp_resp(a) || rd !== exp_mem[mem_idx(a)]) begin
                    n_err++; $display("FAIL rnd_rd%0d addr=%h done=%0d data=%h resp=%0d want 1/%h/%0d",
                                      t, a, ok, rd, r, exp_mem[mem_idx(a)], exp_resp(a));
                end
            end
        end
        ip_delay = 0;
    endtask

    initial begin
        clear_exp();
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_read_backpressure();
        test_simultaneous();
        test_error_resp();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid_write();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit reached=1 want=0");
        $fatal(1, "time limit");
    end

endmodule
